// File: rtl/btn_scan_pkg.sv
// Shared constants for the button scan controller: register map, FSM states
// and the CTRL enable bit position.
package btn_scan_pkg;

   localparam logic [1:0] REG_STATE   = 2'd0;
   localparam logic [1:0] REG_PENDING = 2'd1;
   localparam logic [1:0] REG_IRQ_EN  = 2'd2;
   localparam logic [1:0] REG_CTRL    = 2'd3;

   localparam int CTRL_EN_BIT = 0;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_t;

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchronizer bringing raw asynchronous button levels into the
// clk_i domain.
module btn_sync2 #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] sync
);

   logic [WIDTH-1:0] meta;

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge value of its source, which is what makes this a chain.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

endmodule

// File: rtl/btn_scan_ctrl.sv
// Debounce controller: a slow sample tick launches a scan that walks every
// button through one shared compare/count datapath, plus a small register file.
module btn_scan_ctrl
   import btn_scan_pkg::*;
#(
   parameter int N_BTN      = 4,
   parameter int TICK_DIV   = 10000,
   parameter int STABLE_CNT = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_BTN-1:0] btn_i,
   input  logic             we_i,
   input  logic [3:0]       addr_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o,
   output logic             irq_o
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
   localparam logic [PW-1:0] PRESC_LAST   = PW'(TICK_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST     = IW'(N_BTN - 1);
   localparam logic [3:0]    STABLE_LIMIT = 4'(STABLE_CNT);

   logic [N_BTN-1:0] sync;
   logic [PW-1:0]    presc;
   logic             tick;
   scan_state_t      fsm_state, fsm_next;
   logic [IW-1:0]    idx, idx_next;
   logic [3:0]       cnt [N_BTN];
   logic [N_BTN-1:0] btn_state;
   logic [N_BTN-1:0] pending;
   logic [N_BTN-1:0] irq_en;
   logic             en;

   logic             scanning, cur_sync, cur_state, differs, accept;
   logic [3:0]       cur_cnt, cnt_inc;
   logic [N_BTN-1:0] set_vec, clr_vec;

   btn_sync2 #(.WIDTH(N_BTN)) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .raw   (btn_i),
      .sync  (sync)
   );

   // Tick is registered, so it is high for the one cycle after the wrap to 0.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (en) begin
            if (presc == PRESC_LAST) begin
               presc <= '0;
               tick  <= 1'b1;
            end else begin
               presc <= presc + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         fsm_state <= IDLE;
         idx       <= '0;
      end else begin
         fsm_state <= fsm_next;
         idx       <= idx_next;
      end
   end

   // NOTE: every variable driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      fsm_next = fsm_state;
      idx_next = idx;
      case (fsm_state)
         IDLE: begin
            if (tick) begin
               fsm_next = SCAN;
               idx_next = '0;
            end
         end
         SCAN: begin
            idx_next = idx + IW'(1);
            if (idx == IDX_LAST) fsm_next = IDLE;
         end
         default: fsm_next = IDLE;
      endcase
   end

   // Shared datapath: only the button selected by idx is examined each cycle.
   always_comb begin
      scanning  = (fsm_state == SCAN);
      cur_sync  = sync[idx];
      cur_state = btn_state[idx];
      cur_cnt   = cnt[idx];
      cnt_inc   = cur_cnt + 4'd1;
      differs   = cur_sync ^ cur_state;
      accept    = scanning && differs && (cnt_inc == STABLE_LIMIT);
      set_vec   = '0;
      if (accept && !cur_state) set_vec[idx] = 1'b1;
      clr_vec   = '0;
      if (we_i && addr_i[3:2] == REG_PENDING) clr_vec = wdata_i[N_BTN-1:0];
   end

   // NOTE: the per-button counters are a small flop array, not a RAM, and are
   // cleared on reset because acceptance depends on their starting value.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cnt       <= '{default: '0};
         btn_state <= '0;
      end else if (scanning) begin
         if (!differs) begin
            cnt[idx] <= '0;
         end else if (accept) begin
            cnt[idx]       <= '0;
            btn_state[idx] <= ~cur_state;
         end else begin
            cnt[idx] <= cnt_inc;
         end
      end
   end

   // A rising acceptance in the same cycle as a W1C of that bit keeps it set.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         pending <= '0;
         irq_en  <= '0;
         en      <= 1'b1;
      end else begin
         pending <= (pending & ~clr_vec) | set_vec;
         if (we_i && addr_i[3:2] == REG_IRQ_EN) irq_en <= wdata_i[N_BTN-1:0];
         if (we_i && addr_i[3:2] == REG_CTRL)   en     <= wdata_i[CTRL_EN_BIT];
      end
   end

   always_comb begin
      rdata_o = '0;
      case (addr_i[3:2])
         REG_STATE:   rdata_o[N_BTN-1:0]   = btn_state;
         REG_PENDING: rdata_o[N_BTN-1:0]   = pending;
         REG_IRQ_EN:  rdata_o[N_BTN-1:0]   = irq_en;
         REG_CTRL:    rdata_o[CTRL_EN_BIT] = en;
         default:     rdata_o              = '0;
      endcase
   end

   assign irq_o = |(pending & irq_en);

   logic unused_bits;
   assign unused_bits = &{1'b0, addr_i[1:0], wdata_i[31:N_BTN]};

endmodule

// File: doc/btn_scan_ctrl.md
BTN_SCAN_CTRL -- requirements
Module: btn_scan_ctrl

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of button/switch inputs (1..16).
REQ-002 SHALL have parameter TICK_DIV, default 10000, clock cycles per sample tick, with TICK_DIV >= N_BTN+2.
REQ-003 SHALL have parameter STABLE_CNT, default 4, consecutive differing samples required to accept a change (2..15).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port btn_i, input, N_BTN, raw asynchronous button/switch levels.
REQ-007 SHALL have port we_i, input, 1, bus write strobe.
REQ-008 SHALL have port addr_i, input, 4, byte address of the register; bits [3:2] select the register.
REQ-009 SHALL have port wdata_i, input, 32, write data.
REQ-010 SHALL have port rdata_o, output, 32, read data, combinational from addr_i.
REQ-011 SHALL have port irq_o, output, 1, level interrupt.

Function
REQ-012 SHALL pass btn_i through a 2-FF synchronizer to produce sync[i] before any use.
REQ-013 SHALL use a prescaler counting 0..TICK_DIV-1 while CTRL.EN=1; tick pulses for 1 cycle when count wraps to 0; the counter holds when EN=0.
REQ-014 SHALL use a scan FSM with states IDLE and SCAN: IDLE->SCAN on tick with idx=0; in SCAN it processes button idx in that cycle and increments idx; after idx=N_BTN-1 it goes to IDLE; a single shared compare/count datapath serves all buttons.
REQ-015 SHALL, when processing idx, keep cnt[idx] at 0 if sync[idx]==state[idx]; otherwise increment cnt[idx], and when it reaches STABLE_CNT, toggle state[idx] and clear cnt[idx] at the same edge.
REQ-016 SHALL set pending[idx] at the same edge in which state[idx] goes 0->1; falling edges set nothing.
REQ-017 SHALL provide these registers: 0x0 STATE (RO, state[N-1:0]); 0x4 PENDING (write-1-to-clear); 0x8 IRQ_EN (RW, N bits); 0xC CTRL (bit0 EN, RW). Unused bits read 0, and writes to RO bits are ignored.
REQ-018 SHALL give set priority over clear when a PENDING W1C and a set for the same bit occur in the same cycle; the bit stays 1.
REQ-019 SHALL drive irq_o = |(pending & irq_en) from registers, so it is asserted the cycle after the setting edge.
REQ-020 SHALL, when EN is written 0 during SCAN, complete the current scan to IDLE and then issue no further ticks; counts and state are retained.
REQ-021 SHALL take effect on the clock edge for writes; reads are zero-wait and never have side effects.
REQ-022 SHALL have a worst-case acceptance latency of STABLE_CNT ticks plus idx+1 cycles plus 2 synchronizer cycles after a stable input change.

Reset
REQ-023 SHALL, when rst_i=0 at a clock edge, clear the prescaler, idx, cnt, state, pending, IRQ_EN, and the synchronizer, set the FSM to IDLE and CTRL.EN to 1, and drive irq_o to 0.
REQ-024 SHALL let reset override a simultaneous bus write or an in-progress scan; no event is retained.

Structure
REQ-025 SHALL have a package btn_scan_pkg holding the register offset constants, the FSM state enum (IDLE, SCAN), and the CTRL bit index.
REQ-026 SHALL implement the synchronizer as sub-module btn_sync2 (parameterized width, 2 flops), instantiated once.

Verification (N_BTN=4, TICK_DIV=8, STABLE_CNT=3)
REQ-027 SHALL test reset: hold rst_i=0 for 2 cycles -> STATE=0, PENDING=0, IRQ_EN=0, CTRL=1, irq_o=0.
REQ-028 SHALL test a clean press: btn_i=0001 held -> STATE bit0=1 on the 3rd tick scan, PENDING=0x1; with IRQ_EN=0x1, irq_o=1 the next cycle.
REQ-029 SHALL test bounce: btn_i[2] toggles every 5 cycles for 60 cycles then settles to 1 -> no STATE/PENDING change until 3 consecutive stable ticks, then exactly one PENDING bit2 set.
REQ-030 SHALL test W1C collision: write 0x4<-0x1 in the same cycle bit0 is set -> PENDING bit0 remains 1; a later write 0x1 clears it and irq_o falls next cycle.
REQ-031 SHALL test enable: write CTRL=0 mid-SCAN -> the scan finishes at idx=3, then no tick for 50 cycles and STATE frozen; write CTRL=1 -> ticks resume.
REQ-032 SHALL test release: STATE bit1=1, then btn_i[1]->0 -> STATE bit1=0 after 3 ticks and PENDING unchanged.
